// File: rtl/fft_frame_serializer_if.sv
`default_nettype none
// ============================================================================
// fft_frame_serializer_if: frame-in / beat-out handshake bundle.
// Rev 1.0
// ============================================================================
interface fft_frame_serializer_if #(
  parameter int DATA_WIDTH = 12
);
  logic                         i_valid;
  logic                         o_ready;
  logic signed [DATA_WIDTH-1:0] i_data [16][2];
  logic                         o_valid;
  logic                         i_ready;
  logic signed [DATA_WIDTH-1:0] o_data [4][2];
  logic [1:0]                   o_beat;
  logic                         o_last;
  logic [7:0]                   o_frames;

  modport slave (
    input  i_valid, i_data, i_ready,
    output o_ready, o_valid, o_data, o_beat, o_last, o_frames
  );

  modport master (
    output i_valid, i_data, i_ready,
    input  o_ready, o_valid, o_data, o_beat, o_last, o_frames
  );
endinterface
`default_nettype wire

// File: rtl/fft_frame_serializer.sv
`default_nettype none
// ============================================================================
// fft_frame_serializer: ping-pong buffered 16-sample frames emitted as 4 beats.
// Rev 1.0
// ============================================================================
module fft_frame_serializer #(
  parameter int DATA_WIDTH = 12
) (
  input logic                    clk,
  input logic                    rst_sync,
  fft_frame_serializer_if.slave  bus
);

  logic signed [DATA_WIDTH-1:0] frame_buf [2][16][2];
  logic       wr;
  logic       rd;
  logic [1:0] cnt;
  logic [1:0] beat;
  logic [7:0] frames;

  logic ready;
  logic valid;
  logic accept;
  logic xfer;
  logic last_xfer;

  // Handshake flags depend only on registered occupancy, never on i_ready.
  assign ready     = (cnt != 2'd2);
  assign valid     = (cnt != 2'd0);
  assign accept    = bus.i_valid && ready;
  assign xfer      = valid && bus.i_ready;
  assign last_xfer = xfer && (beat == 2'd3);

  always_ff @(posedge clk) begin
    if (rst_sync) begin
      wr     <= 1'b0;
      rd     <= 1'b0;
      cnt    <= 2'd0;
      beat   <= 2'd0;
      frames <= 8'd0;
    end else begin
      if (accept) begin
        wr <= ~wr;
      end
      if (xfer) begin
        beat <= beat + 2'd1;
      end
      if (last_xfer) begin
        rd     <= ~rd;
        frames <= frames + 8'd1;
      end
      case ({accept, last_xfer})
        2'b10:   cnt <= cnt + 2'd1;
        2'b01:   cnt <= cnt - 2'd1;
        default: cnt <= cnt;
      endcase
    end
  end

  // Buffer storage carries no reset; wr never aliases rd while rd is being read.
  always_ff @(posedge clk) begin
    if (accept) begin
      for (int n = 0; n < 16; n++) begin
        for (int c = 0; c < 2; c++) begin
          frame_buf[wr][n][c] <= bus.i_data[n][c];
        end
      end
    end
  end

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      for (int c = 0; c < 2; c++) begin
        bus.o_data[i][c] = '0;
        if (valid) begin
          bus.o_data[i][c] = frame_buf[rd][{beat, 2'(i)}][c];
        end
      end
    end
  end

  assign bus.o_ready  = ready;
  assign bus.o_valid  = valid;
  assign bus.o_beat   = valid ? beat : 2'd0;
  assign bus.o_last   = valid && (beat == 2'd3);
  assign bus.o_frames = frames;

endmodule
`default_nettype wire

// File: tb/tb_fft_frame_serializer.sv
`default_nettype none
// tb_fft_frame_serializer: randomized and directed checks against a frame-queue model.
module tb_fft_frame_serializer;
  localparam int DW = 12;
  localparam int BW = 4 * 2 * DW;
  typedef logic [16*2*DW-1:0] frame_t;
  typedef logic [BW+12:0] obs_t;

  logic clk;
  logic rst_sync;

  fft_frame_serializer_if #(.DATA_WIDTH(DW)) bus ();
  fft_frame_serializer #(.DATA_WIDTH(DW)) dut (.clk(clk), .rst_sync(rst_sync), .bus(bus));

  int     tests = 0;
  int     fails = 0;
  frame_t mq[$];
  int     mbeat = 0;
  int     mframes = 0;
  frame_t cur_frame;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d failed=%0d", tests, fails);
    $fatal(1);
  end

  function automatic frame_t rand_frame();
    frame_t f;
    for (int j = 0; j < 32; j++) f[j*DW +: DW] = DW'($urandom);
    return f;
  endfunction

  function automatic frame_t extreme_frame();
    frame_t f;
    for (int j = 0; j < 32; j++) f[j*DW +: DW] = ($urandom_range(0, 1) == 1) ? 12'h7FF : 12'h800;
    return f;
  endfunction

  task automatic drive_frame(input frame_t f);
    cur_frame = f;
    for (int n = 0; n < 16; n++)
      for (int c = 0; c < 2; c++)
        bus.i_data[n][c] = f[(n*2+c)*DW +: DW];
  endtask

  function automatic logic [BW-1:0] pack_out();
    logic [BW-1:0] d;
    for (int i = 0; i < 4; i++)
      for (int c = 0; c < 2; c++)
        d[(i*2+c)*DW +: DW] = bus.o_data[i][c];
    return d;
  endfunction

  function automatic obs_t out_bits();
    return {bus.o_ready, bus.o_valid, bus.o_last, bus.o_beat, bus.o_frames, pack_out()};
  endfunction

  // Expected outputs: head of the accepted-frame queue, current beat, frames sent.
  function automatic obs_t exp_bits();
    logic          v, r, l;
    logic [1:0]    b;
    logic [BW-1:0] d;
    frame_t        h;
    v = (mq.size() > 0);
    r = (mq.size() < 2);
    l = v && (mbeat == 3);
    b = v ? 2'(mbeat) : 2'd0;
    d = '0;
    if (v) begin
      h = mq[0];
      d = h[mbeat*BW +: BW];
    end
    return {r, v, l, b, 8'(mframes), d};
  endfunction

  task automatic tick();
    bit acc, xf;
    @(posedge clk);
    if (rst_sync) begin
      mq.delete();
      mbeat   = 0;
      mframes = 0;
    end else begin
      acc = bus.i_valid && (mq.size() < 2);
      xf  = (mq.size() > 0) && bus.i_ready;
      if (xf) begin
        if (mbeat == 3) begin
          void'(mq.pop_front());
          mbeat   = 0;
          mframes = (mframes + 1) % 256;
        end else begin
          mbeat++;
        end
      end
      if (acc) mq.push_back(cur_frame);
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_sync = 1'b1;
    tick();
    tick();
    rst_sync = 1'b0;
    tests++;
    if (out_bits() !== exp_bits()) begin
      fails++;
      $display("FAIL reset_model: got %h expected %h", out_bits(), exp_bits());
    end
    tests++;
    if (bus.o_ready !== 1'b1 || bus.o_valid !== 1'b0 || bus.o_last !== 1'b0 ||
        pack_out() !== '0 || bus.o_frames !== 8'd0 || bus.o_beat !== 2'd0) begin
      fails++;
      $display("FAIL reset_state: got rdy=%b vld=%b last=%b beat=%0d frames=%0d data=%h expected rdy=1 vld=0 last=0 beat=0 frames=0 data=0",
               bus.o_ready, bus.o_valid, bus.o_last, bus.o_beat, bus.o_frames, pack_out());
    end
  endtask

  task automatic test_single_frame();
    frame_t f;
    int     seen = 0;
    for (int n = 0; n < 16; n++) begin
      f[(2*n)*DW +: DW]   = DW'(n);
      f[(2*n+1)*DW +: DW] = DW'(-n);
    end
    bus.i_ready = 1'b1;
    bus.i_valid = 1'b1;
    drive_frame(f);
    for (int c = 0; c < 7; c++) begin
      tests++;
      if (out_bits() !== exp_bits()) begin
        fails++;
        $display("FAIL single_model cyc %0d: got %h expected %h", c, out_bits(), exp_bits());
      end
      if (bus.o_valid) begin
        tests++;
        if (seen > 3 || bus.o_beat !== 2'(seen) || bus.o_data[0][0] !== DW'(4*seen) ||
            bus.o_data[3][1] !== DW'(-(4*seen+3)) || bus.o_last !== (seen == 3)) begin
          fails++;
          $display("FAIL single_beat %0d: got beat=%0d re0=%0d im3=%0d last=%b expected beat=%0d re0=%0d im3=%0d last=%b",
                   seen, bus.o_beat, bus.o_data[0][0], bus.o_data[3][1], bus.o_last,
                   seen, 4*seen, -(4*seen+3), (seen == 3));
        end
        seen++;
      end
      tick();
      bus.i_valid = 1'b0;
    end
    tests++;
    if (seen != 4 || bus.o_frames !== 8'd1) begin
      fails++;
      $display("FAIL single_count: got beats=%0d frames=%0d expected beats=4 frames=1", seen, bus.o_frames);
    end
  endtask

  task automatic test_backpressure();
    frame_t fr[3];
    int     f0;
    int     nx = 0;
    for (int j = 0; j < 3; j++) fr[j] = rand_frame();
    bus.i_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      bus.i_valid = 1'b1;
      drive_frame(fr[c]);
      tests++;
      if (out_bits() !== exp_bits()) begin
        fails++;
        $display("FAIL bp_offer cyc %0d: got %h expected %h", c, out_bits(), exp_bits());
      end
      tick();
    end
    bus.i_valid = 1'b0;
    for (int c = 0; c < 4; c++) begin
      tests++;
      if (bus.o_ready !== 1'b0 || bus.o_valid !== 1'b1 || bus.o_beat !== 2'd0 || pack_out() !== fr[0][BW-1:0]) begin
        fails++;
        $display("FAIL bp_frozen cyc %0d: got rdy=%b vld=%b beat=%0d data=%h expected rdy=0 vld=1 beat=0 data=%h",
                 c, bus.o_ready, bus.o_valid, bus.o_beat, pack_out(), fr[0][BW-1:0]);
      end
      tick();
    end
    f0 = mframes;
    bus.i_ready = 1'b1;
    for (int c = 0; c < 12; c++) begin
      tests++;
      if (out_bits() !== exp_bits()) begin
        fails++;
        $display("FAIL bp_drain cyc %0d: got %h expected %h", c, out_bits(), exp_bits());
      end
      if (bus.o_valid) begin
        tests++;
        if (nx >= 8 || pack_out() !== fr[nx/4][(nx%4)*BW +: BW]) begin
          fails++;
          $display("FAIL bp_beat %0d: got %h expected beat from frame %0d", nx, pack_out(), nx/4);
        end
        nx++;
      end
      tick();
    end
    tests++;
    if (nx != 8 || bus.o_frames !== 8'((f0 + 2) % 256)) begin
      fails++;
      $display("FAIL bp_count: got beats=%0d frames=%0d expected beats=8 frames=%0d", nx, bus.o_frames, (f0 + 2) % 256);
    end
  endtask

  task automatic test_toggle_ready();
    frame_t f;
    int     got[$];
    bit     ok;
    f = rand_frame();
    bus.i_ready = 1'b0;
    bus.i_valid = 1'b1;
    drive_frame(f);
    tick();
    bus.i_valid = 1'b0;
    for (int c = 0; c < 10; c++) begin
      bus.i_ready = (c % 2 == 0);
      tests++;
      if (out_bits() !== exp_bits()) begin
        fails++;
        $display("FAIL toggle_model cyc %0d: got %h expected %h", c, out_bits(), exp_bits());
      end
      if (bus.o_valid && bus.i_ready) begin
        tests++;
        if (got.size() > 3 || pack_out() !== f[got.size()*BW +: BW]) begin
          fails++;
          $display("FAIL toggle_data xfer %0d: got %h", got.size(), pack_out());
        end
        got.push_back(int'(bus.o_beat));
      end
      tick();
    end
    ok = (got.size() == 4);
    for (int j = 0; j < 4; j++) if (ok && got[j] != j) ok = 0;
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL toggle_order: got %0d transfers (order %p) expected 0,1,2,3", got.size(), got);
    end
  endtask

  task automatic test_overlap();
    frame_t fa, fb;
    bit     hit = 0;
    fa = rand_frame();
    fb = rand_frame();
    bus.i_ready = 1'b1;
    bus.i_valid = 1'b1;
    drive_frame(fa);
    tick();
    bus.i_valid = 1'b0;
    for (int c = 0; c < 8 && !hit; c++) begin
      tests++;
      if (out_bits() !== exp_bits()) begin
        fails++;
        $display("FAIL overlap_model cyc %0d: got %h expected %h", c, out_bits(), exp_bits());
      end
      if (bus.o_last) begin
        hit = 1;
        bus.i_valid = 1'b1;
        drive_frame(fb);
      end
      tick();
      bus.i_valid = 1'b0;
    end
    tests++;
    if (!hit || bus.o_valid !== 1'b1 || bus.o_beat !== 2'd0 || bus.o_ready !== 1'b1 || pack_out() !== fb[BW-1:0]) begin
      fails++;
      $display("FAIL overlap_next: got hit=%b vld=%b beat=%0d rdy=%b data=%h expected hit=1 vld=1 beat=0 rdy=1 data=%h",
               hit, bus.o_valid, bus.o_beat, bus.o_ready, pack_out(), fb[BW-1:0]);
    end
    for (int c = 0; c < 6; c++) begin
      tests++;
      if (out_bits() !== exp_bits()) begin
        fails++;
        $display("FAIL overlap_tail cyc %0d: got %h expected %h", c, out_bits(), exp_bits());
      end
      tick();
    end
  endtask

  task automatic test_reset_midframe();
    bus.i_ready = 1'b1;
    bus.i_valid = 1'b1;
    drive_frame(rand_frame());
    tick();
    bus.i_valid = 1'b0;
    tick();
    tick();
    tests++;
    if (bus.o_beat !== 2'd2 || bus.o_valid !== 1'b1) begin
      fails++;
      $display("FAIL midrst_pre: got beat=%0d vld=%b expected beat=2 vld=1", bus.o_beat, bus.o_valid);
    end
    rst_sync    = 1'b1;
    bus.i_valid = 1'b1;
    drive_frame(rand_frame());
    tick();
    rst_sync    = 1'b0;
    bus.i_valid = 1'b0;
    tests++;
    if (bus.o_valid !== 1'b0 || pack_out() !== '0 || bus.o_frames !== 8'd0 || bus.o_ready !== 1'b1 || bus.o_last !== 1'b0) begin
      fails++;
      $display("FAIL midrst_after: got vld=%b data=%h frames=%0d rdy=%b last=%b expected vld=0 data=0 frames=0 rdy=1 last=0",
               bus.o_valid, pack_out(), bus.o_frames, bus.o_ready, bus.o_last);
    end
    for (int c = 0; c < 6; c++) begin
      tests++;
      if (bus.o_valid !== 1'b0 || out_bits() !== exp_bits()) begin
        fails++;
        $display("FAIL midrst_quiet cyc %0d: got %h expected %h", c, out_bits(), exp_bits());
      end
      tick();
    end
  endtask

  task automatic test_random_stream();
    for (int c = 0; c < 400; c++) begin
      bus.i_valid = ($urandom_range(0, 1) == 1);
      bus.i_ready = ($urandom_range(0, 3) != 0);
      drive_frame(rand_frame());
      tests++;
      if (out_bits() !== exp_bits()) begin
        fails++;
        $display("FAIL random cyc %0d: got %h expected %h", c, out_bits(), exp_bits());
      end
      tick();
    end
    bus.i_valid = 1'b0;
  endtask

  task automatic test_wrap();
    int accepted = 0;
    int acc2 = -1, acc255 = -1;
    int vfirst = -1, vlast = -1, vcount = 0;
    rst_sync    = 1'b1;
    bus.i_valid = 1'b0;
    tick();
    rst_sync    = 1'b0;
    bus.i_ready = 1'b1;
    for (int c = 0; c < 1040; c++) begin
      bus.i_valid = (accepted < 256);
      drive_frame(extreme_frame());
      tests++;
      if (out_bits() !== exp_bits()) begin
        fails++;
        $display("FAIL wrap_model cyc %0d: got %h expected %h", c, out_bits(), exp_bits());
      end
      if (bus.o_valid) begin
        if (vfirst < 0) vfirst = c;
        vlast = c;
        vcount++;
      end
      if (bus.i_valid && bus.o_ready) begin
        if (accepted == 2) acc2 = c;
        if (accepted == 255) acc255 = c;
        accepted++;
      end
      tick();
    end
    bus.i_valid = 1'b0;
    tests++;
    if (accepted != 256 || bus.o_frames !== 8'd0 || bus.o_valid !== 1'b0) begin
      fails++;
      $display("FAIL wrap_count: got accepted=%0d frames=%0d vld=%b expected accepted=256 frames=0 vld=0",
               accepted, bus.o_frames, bus.o_valid);
    end
    tests++;
    if (acc255 - acc2 != 253 * 4) begin
      fails++;
      $display("FAIL wrap_rate: got %0d cycles for 253 accepts expected %0d", acc255 - acc2, 253 * 4);
    end
    tests++;
    if (vcount != 1024 || vlast - vfirst + 1 != 1024) begin
      fails++;
      $display("FAIL wrap_gapless: got %0d valid cycles spanning %0d expected 1024 spanning 1024",
               vcount, vlast - vfirst + 1);
    end
  endtask

  initial begin
    rst_sync    = 1'b1;
    bus.i_valid = 1'b0;
    bus.i_ready = 1'b0;
    drive_frame('0);
    test_reset();
    test_single_frame();
    test_backpressure();
    test_toggle_ready();
    test_overlap();
    test_reset_midframe();
    test_random_stream();
    test_wrap();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fft_frame_serializer.md
FFT_FRAME_SERIALIZER -- requirements
Module: fft_frame_serializer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 12: width of each signed real/imag component, the FFT result width.
REQ-002 SHALL have port clk, input, 1: single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_sync, input, 1: reset, synchronous and active-high.
REQ-004 SHALL have port i_valid, input, 1: a full 16-sample frame is present on i_data.
REQ-005 SHALL have port o_ready, output, 1: block can accept a frame this cycle.
REQ-006 SHALL have port i_data, input, [16][2] x DATA_WIDTH signed: frame, element 0 real, element 1 imaginary.
REQ-007 SHALL have port o_valid, output, 1: o_data holds a valid beat.
REQ-008 SHALL have port i_ready, input, 1: downstream accepts the current beat.
REQ-009 SHALL have port o_data, output, [4][2] x DATA_WIDTH signed: 4 complex samples per beat.
REQ-010 SHALL have port o_beat, output, 2: index k (0..3) of the current beat.
REQ-011 SHALL have port o_last, output, 1: current beat is the final beat (k=3) of a frame.
REQ-012 SHALL have port o_frames, output, 8: count of fully transmitted frames.

Function
REQ-013 SHALL hold two frame buffers (ping-pong), write pointer wr, read pointer rd, occupancy cnt in 0..2, and beat counter k.
REQ-014 SHALL drive o_ready = (cnt < 2) from registered state only, with no same-cycle dependence on i_ready.
REQ-015 SHALL accept a frame when i_valid && o_ready: copy i_data into buffer[wr], toggle wr, increment cnt; i_valid with o_ready low is ignored and the frame is not stored.
REQ-016 SHALL drive o_valid = (cnt > 0); the first beat of a frame accepted at edge N is valid in the cycle after edge N (1-cycle latency).
REQ-017 SHALL present on beat k, lane i (i = 0..3), sample 4k+i of buffer[rd], both components unmodified (no scaling or rounding).
REQ-018 SHALL drive o_data to all zeros and o_beat to 0 while o_valid is low.
REQ-019 SHALL transfer a beat when o_valid && i_ready; on transfer with k<3, k increments.
REQ-020 SHALL, on a transfer with k=3: set k=0, toggle rd, decrement cnt, increment o_frames (wrap 255 -> 0).
REQ-021 SHALL hold o_data, o_beat and o_last stable while o_valid && !i_ready.
REQ-022 SHALL drive o_last = o_valid && (k == 3).
REQ-023 SHALL, on simultaneous frame accept and final-beat transfer, leave cnt unchanged, toggle both wr and rd, and start the next frame at k=0 on the following cycle.
REQ-024 SHALL, with cnt=2, sustain back-to-back frames with no idle cycle between the last beat of one frame and beat 0 of the next while i_ready is high.
REQ-025 SHALL, with i_valid held high and i_ready held high, sustain one accepted frame per 4 cycles at steady state.

Reset
REQ-026 SHALL, while rst_sync is high at a rising edge, set cnt=0, wr=0, rd=0, k=0, o_frames=0; o_valid=0, o_last=0, o_data=0 and o_ready=1 in the following cycle.
REQ-027 SHALL, on reset mid-frame, discard all buffered and partially transmitted frames with no further beats emitted and o_frames not incremented.
REQ-028 SHALL NOT require buffer contents to be reset.

Verification
REQ-029 SHALL cover: single frame, sample n real=n, imag=-n, i_ready=1 -> 4 beats on consecutive cycles, beat k lanes real 4k..4k+3, o_last on k=3 only, o_frames=1.
REQ-030 SHALL cover: 3 frames offered back-to-back with i_ready=0 -> frames 1 and 2 accepted, o_ready=0 with cnt=2, frame 3 not stored; o_data frozen at frame 1 beat 0.
REQ-031 SHALL cover: i_ready toggling 1,0,1,0 during a frame -> each beat held until i_ready=1, order 0,1,2,3, no beat duplicated or skipped.
REQ-032 SHALL cover: new frame offered on the cycle frame A's beat 3 transfers -> accepted, frame B beat 0 valid next cycle, cnt unchanged.
REQ-033 SHALL cover: rst_sync asserted after beat 1 of a frame -> o_valid=0, o_data=0, o_frames=0 next cycle, o_ready=1, no further beats.
REQ-034 SHALL cover: 256 frames with extreme values (+2047/-2048, DATA_WIDTH=12) -> values passed bit-exact, o_frames wraps to 0.
